// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start(0), DATA_W data bits, even parity, stop(1).
// Each bit is held CLKS_PER_BIT cycles; tx_out comes straight from a flop.
//
// state  | meaning
// IDLE   | line high, in_ready high, waiting for a word
// START  | line low for one bit time
// DATA   | shifting out DATA_W payload bits
// PARITY | even parity of the latched word
// STOP   | line high for one bit time, frame_done in its last cycle
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              cyc_last;
  logic [DATA_W-1:0] sh_next;

  function automatic logic head(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  assign cyc_last = (cyc_q == CYC_LAST);
  assign sh_next  = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is the line value for the cycle after the edge, so tx_q lines up with state_q.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    par_d      = par_q;
    tx_d       = tx_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cyc_d = '0;
        bit_d = '0;
        if (in_valid) begin
          state_d = START;
          sh_d    = in_data;
          par_d   = ^in_data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (cyc_last) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = head(sh_q);
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      DATA: begin
        if (cyc_last) begin
          cyc_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            bit_d = bit_q + 1'b1;
            sh_d  = sh_next;
            tx_d  = head(sh_next);
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      PARITY: begin
        if (cyc_last) begin
          cyc_d   = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (cyc_last) begin
          frame_done = 1'b1;
          cyc_d      = '0;
          state_d    = IDLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign in_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign tx_out   = tx_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three instances (LSB/4, MSB/4, LSB/1) checked by
// hand-derived frame tables, directed corner sequences and a per-cycle reference model.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [2:0] vld = 3'b000;
  logic [2:0] rdy, tx, busy, done;

  int errors = 0;
  int checks = 0;

  int cpb [3] = '{4, 4, 1};
  bit msb [3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(vld[0]), .in_ready(rdy[0]),
    .tx_out(tx[0]), .tx_busy(busy[0]), .frame_done(done[0]));
  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(vld[1]), .in_ready(rdy[1]),
    .tx_out(tx[1]), .tx_busy(busy[1]), .frame_done(done[1]));
  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(vld[2]), .in_ready(rdy[2]),
    .tx_out(tx[2]), .tx_busy(busy[2]), .frame_done(done[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles since accept (0 = idle) and the word accepted.
  int         m_t [3] = '{0, 0, 0};
  logic [7:0] m_w [3];

  function automatic logic sym(input logic [7:0] w, input int idx, input bit m);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m ? w[8 - idx] : w[idx - 1];
    if (idx == 9) return ^w;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int d = 0; d < 3; d++) begin
      if (!reset) m_t[d] = 0;
      else if (m_t[d] == 0) begin
        if (vld[d]) begin
          m_w[d] = in_data;
          m_t[d] = 1;
        end
      end else if (m_t[d] == 11 * cpb[d]) m_t[d] = 0;
      else m_t[d] = m_t[d] + 1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      for (int d = 0; d < 3; d++) begin
        int t;
        t = m_t[d];
        chk($sformatf("model d%0d tx_out", d), tx[d],
            (t == 0) ? 1'b1 : sym(m_w[d], (t - 1) / cpb[d], msb[d]));
        chk($sformatf("model d%0d in_ready", d), rdy[d], t == 0);
        chk($sformatf("model d%0d tx_busy", d), busy[d], t != 0);
        chk($sformatf("model d%0d frame_done", d), done[d], t == 11 * cpb[d]);
      end
    end
  end

  task automatic send(input int d, input logic [7:0] w);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rdy[d]) break;
    end
    if (i == 200) chk("send ready timeout", 0, 1);
    vld[d]  = 1'b1;
    in_data = w;
    @(posedge clk);
  endtask

  // mode 0: drop valid; 1: hold valid and present nxt; 2: toggle data and pulse valid mid-frame
  task automatic check_line(input int d, input logic [10:0] pat, input int mode, input logic [7:0] nxt);
    int f;
    f = 11 * cpb[d];
    for (int c = 1; c <= f; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (mode == 1) in_data = nxt;
        else vld[d] = 1'b0;
      end
      if (mode == 2) begin
        in_data = 8'($urandom);
        vld[d]  = (c % 2) == 1;
        if (c == f) vld[d] = 1'b0;
      end
      chk($sformatf("d%0d line c%0d", d, c), tx[d], pat[10 - (c - 1) / cpb[d]]);
      chk($sformatf("d%0d frame_done c%0d", d, c), done[d], c == f);
      chk($sformatf("d%0d in_ready low c%0d", d, c), rdy[d], 1'b0);
    end
    @(negedge clk);
    chk($sformatf("d%0d in_ready after frame", d), rdy[d], 1'b1);
    chk($sformatf("d%0d idle line", d), tx[d], 1'b1);
  endtask

  typedef struct {
    int         d;
    logic [7:0] w;
    logic [10:0] pat;
    int         mode;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{0, 8'hA5, 11'b01010010101, 0};
    tbl[1] = '{0, 8'h01, 11'b01000000011, 0};
    tbl[2] = '{0, 8'hFE, 11'b00111111111, 0};
    tbl[3] = '{1, 8'h01, 11'b00000000111, 0};
    tbl[4] = '{1, 8'hA5, 11'b01010010101, 0};
    tbl[5] = '{2, 8'h80, 11'b00000000111, 0};
    tbl[6] = '{0, 8'hA5, 11'b01010010101, 2};

    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset d%0d tx_out", d), tx[d], 1'b1);
      chk($sformatf("reset d%0d in_ready", d), rdy[d], 1'b1);
      chk($sformatf("reset d%0d tx_busy", d), busy[d], 1'b0);
      chk($sformatf("reset d%0d frame_done", d), done[d], 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].d, tbl[i].w);
      check_line(tbl[i].d, tbl[i].pat, tbl[i].mode, 8'h00);
    end

    // valid held high: second accept lands right after the single idle cycle
    send(0, 8'h3C);
    check_line(0, 11'b00011110001, 1, 8'hC3);
    check_line(0, 11'b01100001101, 0, 8'h00);

    // asynchronous reset mid-DATA, then a clean frame
    send(0, 8'hA5);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreset tx_out", tx[0], 1'b1);
    chk("midreset in_ready", rdy[0], 1'b1);
    chk("midreset tx_busy", busy[0], 1'b0);
    vld[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    send(0, 8'h5A);
    check_line(0, 11'b00101101001, 0, 8'h00);

    // randomized traffic on all instances against the model
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      in_data = 8'($urandom);
      for (int d = 0; d < 3; d++) vld[d] = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    vld = 3'b000;
    repeat (60) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
